// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian host byte stream into words, writes them
// from BASE upward and stalls the core until done. Define IMEM_LOADER_CHECKSUM_EN for a trailing sum.
module imem_loader #(
  parameter int unsigned DEPTH = 256,
  parameter logic [31:0] BASE  = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  indata,
  input  logic        invalid,
  output logic        inready,
  output logic        memwrite,
  output logic [31:0] writeaddr,
  output logic [31:0] writedata,
  output logic [8:0]  loadedcount,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpuhold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;
`endif

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_cnt;
  logic [23:0] partial;
  logic [31:0] word_count;
  logic [31:0] word;
  logic        accept;
  logic        word_done;
  logic        last_word;
  logic        start_taken;
  logic        in_stream;
  logic        ready_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
`endif

  assign accept      = invalid & inready;
  assign word        = {partial, indata};
  assign word_done   = accept && (byte_cnt == 2'd3);
  assign last_word   = (({23'd0, loadedcount}) + 32'd1) == word_count;
  assign start_taken = start && ((state == IDLE) || (state == DONE) || (state == ERR));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = HDR;
      HDR: begin
        if (word_done) begin
          if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_next = CHK;
`else
            state_next = DONE;
`endif
          end else if (word > DEPTH) begin
            state_next = ERR;
          end else begin
            state_next = DATA;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      DATA: if (word_done && last_word) state_next = CHK;
      CHK:  if (word_done) state_next = (word == sum) ? DONE : ERR;
`else
      // Leave only once the final strobe has gone out.
      DATA: if (memwrite && ({23'd0, loadedcount} == word_count)) state_next = DONE;
`endif
      DONE: if (start) state_next = HDR;
      ERR:  if (start) state_next = HDR;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_stream = (state_next == HDR) || (state_next == DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state_next == CHK) in_stream = 1'b1;
    ready_next = in_stream;
`else
    // The last word's strobe cycle is still DATA but must not take another byte.
    ready_next = in_stream && !((state == DATA) && word_done && last_word);
`endif
  end

  // NOTE: all state and outputs update with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      byte_cnt    <= 2'd0;
      partial     <= 24'd0;
      word_count  <= 32'd0;
      inready     <= 1'b0;
      memwrite    <= 1'b0;
      writeaddr   <= 32'd0;
      writedata   <= 32'd0;
      loadedcount <= 9'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cpuhold     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum         <= 32'd0;
`endif
    end else begin
      state    <= state_next;
      inready  <= ready_next;
      busy     <= in_stream;
      done     <= (state_next == DONE);
      error    <= (state_next == ERR);
      cpuhold  <= (state_next != DONE);
      memwrite <= 1'b0;

      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        partial  <= {partial[15:0], indata};
      end

      if ((state == HDR) && word_done) word_count <= word;

      if ((state == DATA) && word_done) begin
        memwrite    <= 1'b1;
        writeaddr   <= BASE + {23'd0, loadedcount};
        writedata   <= word;
        loadedcount <= loadedcount + 9'd1;
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (memwrite) sum <= sum + writedata;
`endif

      if ((state == IDLE) || start_taken) begin
        byte_cnt    <= 2'd0;
        loadedcount <= 9'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum         <= 32'd0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams against a byte-count based
// reference model, compared every cycle, plus literal expectations for the directed images.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  indata;
  logic        invalid;
  logic        inready;
  logic        memwrite;
  logic [31:0] writeaddr;
  logic [31:0] writedata;
  logic [8:0]  loadedcount;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpuhold;

  imem_loader #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .indata(indata), .invalid(invalid),
    .inready(inready), .memwrite(memwrite), .writeaddr(writeaddr), .writedata(writedata),
    .loadedcount(loadedcount), .busy(busy), .done(done), .error(error), .cpuhold(cpuhold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the session purely by bytes accepted versus bytes the image needs.
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_err    = 1'b0;
  bit          m_mw     = 1'b0;
  bit          m_pend   = 1'b0;
  int          m_got    = 0;
  int          m_total  = 0;
  int          m_cnt    = 0;
  logic [31:0] m_n      = 32'd0;
  logic [31:0] m_word   = 32'd0;
  logic [31:0] m_addr   = 32'd0;
  logic [31:0] m_data   = 32'd0;
  logic [31:0] m_sum    = 32'd0;

  task automatic model_reset();
    m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_mw = 1'b0; m_pend = 1'b0;
    m_got = 0; m_total = 0; m_cnt = 0;
    m_n = 32'd0; m_word = 32'd0; m_addr = 32'd0; m_data = 32'd0; m_sum = 32'd0;
  endtask

  task automatic model_word();
    int data_end;
    if (m_got == 4) begin
      m_n = m_word;
      if (m_n > DEPTH) begin
        m_err = 1'b1; m_active = 1'b0;
      end else if (m_n == 32'd0 && !CK) begin
        m_done = 1'b1; m_active = 1'b0;
      end else begin
        m_total = 4 + 4 * int'(m_n) + (CK ? 4 : 0);
      end
    end else begin
      data_end = 4 + 4 * int'(m_n);
      if (m_got <= data_end) begin
        m_mw   = 1'b1;
        m_addr = BASE + 32'(m_cnt);
        m_data = m_word;
        m_cnt++;
        m_sum  = m_sum + m_word;
        if (m_got == data_end && !CK) m_pend = 1'b1;
      end else begin
        if (m_word == m_sum) m_done = 1'b1;
        else m_err = 1'b1;
        m_active = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    bit was_active;
    bit rdy;
    was_active = m_active;
    rdy = m_active && (m_got < m_total);
    m_mw = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_pend) begin
        m_pend = 1'b0; m_active = 1'b0; m_done = 1'b1;
      end
      if (rdy && invalid) begin
        m_got++;
        m_word = {m_word[23:0], indata};
        if ((m_got % 4) == 0) model_word();
      end else if (start && !was_active) begin
        m_active = 1'b1; m_done = 1'b0; m_err = 1'b0;
        m_got = 0; m_total = 4; m_cnt = 0; m_n = 32'd0; m_sum = 32'd0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];

  task automatic compare_outputs();
    if (!rst_n) begin
      check("rst_inready", inready, 0);
      check("rst_memwrite", memwrite, 0);
      check("rst_writeaddr", writeaddr, 0);
      check("rst_writedata", writedata, 0);
      check("rst_loadedcount", loadedcount, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_cpuhold", cpuhold, 1);
    end else begin
      check("inready", inready, m_active && (m_got < m_total));
      check("memwrite", memwrite, m_mw);
      check("writeaddr", writeaddr, m_addr);
      check("writedata", writedata, m_data);
      check("loadedcount", loadedcount, m_cnt);
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("error", error, m_err);
      check("cpuhold", cpuhold, !m_done);
    end
    if (memwrite === 1'b1) begin
      wlog_addr.push_back(writeaddr);
      wlog_data.push_back(writedata);
    end
  endtask

  initial forever begin
    @(negedge clk);
    compare_outputs();
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  // Stimulus helpers; all input changes happen on the falling edge.
  logic [7:0]  byte_q[$];
  logic [31:0] img[$];

  task automatic push_word(input logic [31:0] w);
    byte_q.push_back(w[31:24]);
    byte_q.push_back(w[23:16]);
    byte_q.push_back(w[15:8]);
    byte_q.push_back(w[7:0]);
  endtask

  task automatic queue_image(input bit use_override, input logic [31:0] override);
    logic [31:0] s;
    s = 32'd0;
    byte_q.delete();
    push_word(32'(img.size()));
    foreach (img[i]) begin
      push_word(img[i]);
      s = s + img[i];
    end
    if (CK) push_word(use_override ? override : s);
  endtask

  task automatic random_image(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  task automatic send_q(input bit gaps, input int count);
    int sent;
    int budget;
    int k;
    sent = 0;
    while (byte_q.size() > 0 && sent < count) begin
      if (gaps) begin
        k = $urandom_range(0, 3);
        repeat (k) begin
          invalid = 1'b0;
          indata  = 8'($urandom);
          @(negedge clk);
        end
      end
      indata  = byte_q.pop_front();
      invalid = 1'b1;
      budget  = 0;
      while (inready !== 1'b1 && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 50) begin
        check("send_inready", inready, 1);
        byte_q.delete();
      end else begin
        @(negedge clk);
        sent++;
      end
    end
    invalid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int b;
    b = 0;
    while (!(done === 1'b1 || error === 1'b1) && b < 100) begin
      @(negedge clk);
      b++;
    end
    check({name, "_finished"}, (b < 100), 1);
    @(negedge clk);
  endtask

  task automatic clear_log();
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  initial begin
    start   = 1'b0;
    invalid = 1'b0;
    indata  = 8'd0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cpuhold", cpuhold, 1);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three-word image at one byte per clock; the sum of the three words is 0x4021270F.
    img.delete();
    img.push_back(32'h2010270F);
    img.push_back(32'h20110000);
    img.push_back(32'h00000000);
    for (int pass = 0; pass < 2; pass++) begin
      clear_log();
      queue_image(1'b1, 32'h4021270F);
      pulse_start();
      send_q(pass == 1, 10000);
      wait_end("img3");
      check("img3_writes", wlog_addr.size(), 3);
      check("img3_addr0", wlog_addr[0], 32'd0);
      check("img3_addr2", wlog_addr[2], 32'd2);
      check("img3_data0", wlog_data[0], 32'h2010270F);
      check("img3_data1", wlog_data[1], 32'h20110000);
      check("img3_data2", wlog_data[2], 32'h00000000);
      check("img3_done", done, 1);
      check("img3_cpuhold", cpuhold, 0);
      check("img3_count", loadedcount, 3);
    end

    // Oversized header, bytes offered while stalled, then an empty image.
    clear_log();
    byte_q.delete();
    push_word(32'h00000101);
    pulse_start();
    send_q(1'b0, 10000);
    wait_end("oversize");
    for (int i = 0; i < 5; i++) begin
      invalid = 1'b1;
      indata  = 8'($urandom);
      @(negedge clk);
    end
    invalid = 1'b0;
    check("oversize_error", error, 1);
    check("oversize_writes", wlog_addr.size(), 0);
    check("oversize_inready", inready, 0);
    check("oversize_cpuhold", cpuhold, 1);
    img.delete();
    queue_image(1'b0, 32'd0);
    pulse_start();
    send_q(1'b0, 10000);
    wait_end("empty");
    check("empty_done", done, 1);
    check("empty_count", loadedcount, 0);

    // Two words with a wrong checksum when the checksum is built in.
    clear_log();
    img.delete();
    img.push_back(32'h00000001);
    img.push_back(32'h00000002);
    queue_image(1'b1, 32'hDEADBEEF);
    pulse_start();
    send_q(1'b1, 10000);
    wait_end("badsum");
    check("badsum_writes", wlog_addr.size(), 2);
    check("badsum_error", error, CK);
    check("badsum_done", done, !CK);
    check("badsum_cpuhold", cpuhold, CK);

    // Reset after the second byte of data word 1, then a clean reload.
    random_image(4);
    queue_image(1'b0, 32'd0);
    pulse_start();
    send_q(1'b0, 10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_inready", inready, 0);
    check("midrst_memwrite", memwrite, 0);
    check("midrst_count", loadedcount, 0);
    check("midrst_writeaddr", writeaddr, 0);
    check("midrst_cpuhold", cpuhold, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    random_image(4);
    queue_image(1'b0, 32'd0);
    pulse_start();
    send_q(1'b1, 10000);
    wait_end("reload");
    check("reload_writes", wlog_addr.size(), 4);
    check("reload_addr0", wlog_addr[0], BASE);
    check("reload_done", done, 1);

    // start pulsed in the middle of the data phase is ignored.
    clear_log();
    random_image(5);
    queue_image(1'b0, 32'd0);
    pulse_start();
    send_q(1'b0, 12);
    pulse_start();
    send_q(1'b0, 10000);
    wait_end("midstart");
    check("midstart_count", loadedcount, 5);
    check("midstart_done", done, 1);

    // Random images with random gaps.
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(1, 8);
      clear_log();
      random_image(n);
      queue_image(1'b0, 32'd0);
      pulse_start();
      send_q(1'b1, 10000);
      wait_end("rand");
      check("rand_count", loadedcount, n);
      check("rand_writes", wlog_addr.size(), n);
      check("rand_done", done, 1);
    end

    // Largest legal image.
    clear_log();
    random_image(DEPTH);
    queue_image(1'b0, 32'd0);
    pulse_start();
    send_q(1'b0, 10000);
    wait_end("full");
    check("full_writes", wlog_addr.size(), DEPTH);
    check("full_last_addr", wlog_addr[DEPTH-1], BASE + 32'(DEPTH - 1));
    check("full_count", loadedcount, DEPTH);
    check("full_done", done, 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
